// File: rtl/lockstep_pkg.sv
// Shared types and limits for the lockstep clock-enable sequencer.
package lockstep_pkg;

   localparam int unsigned LAT_MAX   = 8;
   localparam int unsigned CNT_W_DEF = 16;
   localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      RUN,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/ce_tag_delay.sv
// LAT-deep 1-bit tag shift register; a tag leaving the far end marks a cycle whose subsystem
// outputs belong to a compared sample. Advances only when en is high; clr empties it.
module ce_tag_delay #(
   parameter int LAT = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   input  logic tag_in,
   output logic tag_out
);

   logic [LAT-1:0] sr_q;

   // Shift tags toward the output on every enabled cycle.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         sr_q <= '0;
      end else if (en) begin
         sr_q <= (sr_q << 1) | LAT'(tag_in);
      end
   end

   assign tag_out = sr_q[LAT-1];

endmodule

// File: rtl/lockstep_ce_sequencer.sv
// Lockstep run sequencer: drives a shared clock enable for a programmed number of samples,
// compares both redundant subsystems after the pipeline latency and records mismatches.
// Optional LOCKSTEP_SNAPSHOT_EN adds err_val_a/err_val_b capturing the first failing data.
module lockstep_ce_sequencer
   import lockstep_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int LAT    = 2,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk_enable,
   input  logic              start,
   input  logic [CNT_W-1:0]  run_len,
   input  logic              halt_on_err,
   input  logic [DATA_W-1:0] dout_a,
   input  logic [DATA_W-1:0] dout_b,
   input  logic              ce_out_a,
   input  logic              ce_out_b,
   output logic              sub_ce,
   output logic              busy,
   output logic              done,
   output logic              mismatch,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [CNT_W-1:0]  first_err_idx
`ifdef LOCKSTEP_SNAPSHOT_EN
   ,
   output logic [DATA_W-1:0] err_val_a,
   output logic [DATA_W-1:0] err_val_b
`endif
);

   localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] LatLast = CNT_W'(LAT - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  run_len_q;
   logic              halt_q;
   logic [CNT_W-1:0]  idx_q;
   logic [CNT_W-1:0]  err_cnt_q;
   logic [CNT_W-1:0]  first_q;
   logic              mismatch_q;

   logic accept, tag_out, cmp, fail, halt_hit, lat_last;

   assign accept   = clk_enable & start & ((state_q == IDLE) | (state_q == DONE));
   assign cmp      = clk_enable & tag_out & ((state_q == RUN) | (state_q == DRAIN));
   assign fail     = cmp & ((dout_a != dout_b) | (ce_out_a != ce_out_b));
   assign halt_hit = fail & halt_q;
   assign lat_last = (cnt_q == LatLast);

   ce_tag_delay #(
      .LAT(LAT)
   ) u_tag_delay (
      .clk    (clk),
      .reset  (reset),
      .clr    (accept | halt_hit),
      .en     (clk_enable),
      .tag_in (state_q == RUN),
      .tag_out(tag_out)
   );

   // Next state and phase counter; nothing moves without clk_enable.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (clk_enable) begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_d = FILL;
                  cnt_d   = '0;
               end
            end
            FILL: begin
               if (lat_last) begin
                  cnt_d   = '0;
                  state_d = (run_len_q == '0) ? DRAIN : RUN;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            RUN: begin
               if (halt_hit) begin
                  state_d = DONE;
                  cnt_d   = '0;
               end else if (cnt_q == run_len_q - CNT_W'(1)) begin
                  state_d = DRAIN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            DRAIN: begin
               if (halt_hit || lat_last) begin
                  state_d = DONE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and phase counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Run configuration latch and compare bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         run_len_q  <= '0;
         halt_q     <= 1'b0;
         idx_q      <= '0;
         err_cnt_q  <= '0;
         first_q    <= '0;
         mismatch_q <= 1'b0;
      end else if (accept) begin
         run_len_q  <= run_len;
         halt_q     <= halt_on_err;
         idx_q      <= '0;
         err_cnt_q  <= '0;
         first_q    <= '0;
         mismatch_q <= 1'b0;
      end else if (cmp) begin
         idx_q <= idx_q + CNT_W'(1);
         if (fail) begin
            mismatch_q <= 1'b1;
            if (err_cnt_q != CntMax) err_cnt_q <= err_cnt_q + CNT_W'(1);
            if (!mismatch_q) first_q <= idx_q;
         end
      end
   end

`ifdef LOCKSTEP_SNAPSHOT_EN
   logic [DATA_W-1:0] snap_a_q, snap_b_q;

   // Capture both data words of the first failing compare.
   always_ff @(posedge clk) begin
      if (reset || accept) begin
         snap_a_q <= '0;
         snap_b_q <= '0;
      end else if (fail && !mismatch_q) begin
         snap_a_q <= dout_a;
         snap_b_q <= dout_b;
      end
   end

   assign err_val_a = snap_a_q;
   assign err_val_b = snap_b_q;
`endif

   assign sub_ce        = clk_enable & ((state_q == FILL) | (state_q == RUN));
   assign busy          = (state_q == FILL) | (state_q == RUN) | (state_q == DRAIN);
   assign done          = (state_q == DONE);
   assign mismatch      = mismatch_q;
   assign err_cnt       = err_cnt_q;
   assign first_err_idx = first_q;

endmodule

// File: tb/tb_lockstep_ce_sequencer.sv
// Directed bench for lockstep_ce_sequencer (LAT=2, CNT_W=16) plus a CNT_W=4 instance for
// error-counter limits. Enabled-cycle n after an accepted start: FILL n=0..1, RUN n=2..,
// compare k happens in enabled cycle n=4+k.
module tb_lockstep_ce_sequencer;

   localparam int DW = 8;
   localparam int CW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, clk_enable, start, halt_on_err, ce_out_a, ce_out_b;
   logic [CW-1:0] run_len, err_cnt, first_err_idx;
   logic [DW-1:0] dout_a, dout_b;
   logic          sub_ce, busy, done, mismatch;

   logic          start4, sub_ce4, busy4, done4, mismatch4;
   logic [3:0]    run_len4, err_cnt4, first4;
   logic [DW-1:0] dout_a4, dout_b4;

`ifdef LOCKSTEP_SNAPSHOT_EN
   logic [DW-1:0] err_val_a, err_val_b, err_val_a4, err_val_b4;
`endif

   lockstep_ce_sequencer #(.DATA_W(DW), .LAT(2), .CNT_W(CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .clk_enable   (clk_enable),
      .start        (start),
      .run_len      (run_len),
      .halt_on_err  (halt_on_err),
      .dout_a       (dout_a),
      .dout_b       (dout_b),
      .ce_out_a     (ce_out_a),
      .ce_out_b     (ce_out_b),
      .sub_ce       (sub_ce),
      .busy         (busy),
      .done         (done),
      .mismatch     (mismatch),
      .err_cnt      (err_cnt),
      .first_err_idx(first_err_idx)
`ifdef LOCKSTEP_SNAPSHOT_EN
      ,
      .err_val_a    (err_val_a),
      .err_val_b    (err_val_b)
`endif
   );

   lockstep_ce_sequencer #(.DATA_W(DW), .LAT(2), .CNT_W(4)) dut4 (
      .clk          (clk),
      .reset        (reset),
      .clk_enable   (1'b1),
      .start        (start4),
      .run_len      (run_len4),
      .halt_on_err  (1'b0),
      .dout_a       (dout_a4),
      .dout_b       (dout_b4),
      .ce_out_a     (1'b1),
      .ce_out_b     (1'b1),
      .sub_ce       (sub_ce4),
      .busy         (busy4),
      .done         (done4),
      .mismatch     (mismatch4),
      .err_cnt      (err_cnt4),
      .first_err_idx(first4)
`ifdef LOCKSTEP_SNAPSHOT_EN
      ,
      .err_val_a    (err_val_a4),
      .err_val_b    (err_val_b4)
`endif
   );

   int checks = 0;
   int errors = 0;
   int en_n, fault_n, fault_ce_n, sub_ce_cnt, done_at, clocks, n4;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock: drive subsystem outputs for enabled cycle en_n, count sub_ce, advance.
   task automatic tick(input logic en);
      clk_enable = en;
      dout_a     = 8'hA5;
      dout_b     = (en_n == fault_n) ? 8'h5A : 8'hA5;
      ce_out_a   = 1'b1;
      ce_out_b   = (en_n == fault_ce_n) ? 1'b0 : 1'b1;
      #1;
      if (en && sub_ce) sub_ce_cnt++;
      @(posedge clk);
      #1;
      if (en) en_n++;
   endtask

   task automatic start_run(input logic [CW-1:0] len, input logic halt);
      run_len     = len;
      halt_on_err = halt;
      start       = 1'b1;
      clk_enable  = 1'b1;
      @(posedge clk);
      #1;
      start      = 1'b0;
      en_n       = 0;
      sub_ce_cnt = 0;
   endtask

   task automatic run_to_done(input bit toggle);
      clocks = 0;
      while (!done && clocks < 300) begin
         tick(toggle ? ((clocks % 2) == 0) : 1'b1);
         clocks++;
      end
      done_at = done ? en_n : -1;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; clk_enable = 1'b0; run_len = '0; halt_on_err = 1'b0;
      dout_a = 8'hA5; dout_b = 8'hA5; ce_out_a = 1'b1; ce_out_b = 1'b1;
      start4 = 1'b0; run_len4 = 4'd15; dout_a4 = 8'h01; dout_b4 = 8'h02;
      fault_n = -1; fault_ce_n = -1; en_n = 0; sub_ce_cnt = 0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      clk_enable = 1'b1;
      #1;
      check_eq("rst_sub_ce", sub_ce, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_mismatch", mismatch, 0);
      check_eq("rst_err_cnt", err_cnt, 0);
      check_eq("rst_first_idx", first_err_idx, 0);

      // Clean run of 10 samples.
      start_run(10, 1'b0);
      check_eq("t1_busy", busy, 1);
      run_to_done(1'b0);
      check_eq("t1_done_at", done_at, 14);
      check_eq("t1_sub_ce_cnt", sub_ce_cnt, 12);
      check_eq("t1_err_cnt", err_cnt, 0);
      check_eq("t1_mismatch", mismatch, 0);
      check_eq("t1_sub_ce_done", sub_ce, 0);
      check_eq("t1_busy_done", busy, 0);

      // Data fault on sample 3, run continues.
      fault_n = 7;
      start_run(10, 1'b0);
      run_to_done(1'b0);
      check_eq("t2_done_at", done_at, 14);
      check_eq("t2_mismatch", mismatch, 1);
      check_eq("t2_err_cnt", err_cnt, 1);
      check_eq("t2_first_idx", first_err_idx, 3);
`ifdef LOCKSTEP_SNAPSHOT_EN
      check_eq("t2_err_val_a", err_val_a, 8'hA5);
      check_eq("t2_err_val_b", err_val_b, 8'h5A);
`endif

      // Same fault with halt: DONE the cycle after compare 3.
      start_run(10, 1'b1);
      run_to_done(1'b0);
      check_eq("t3_done_at", done_at, 8);
      check_eq("t3_sub_ce_cnt", sub_ce_cnt, 8);
      check_eq("t3_sub_ce_done", sub_ce, 0);
      check_eq("t3_err_cnt", err_cnt, 1);
      check_eq("t3_first_idx", first_err_idx, 3);

      // ce_out fault on sample 1.
      fault_n = -1;
      fault_ce_n = 5;
      start_run(10, 1'b0);
      run_to_done(1'b0);
      check_eq("tce_done_at", done_at, 14);
      check_eq("tce_err_cnt", err_cnt, 1);
      check_eq("tce_first_idx", first_err_idx, 1);
      check_eq("tce_mismatch", mismatch, 1);

      // Toggled clk_enable, 5 samples.
      fault_ce_n = -1;
      start_run(5, 1'b0);
      check_eq("t4_start_clears", mismatch, 0);
      run_to_done(1'b1);
      check_eq("t4_done_at", done_at, 9);
      check_eq("t4_clocks", clocks, 17);
      check_eq("t4_sub_ce_cnt", sub_ce_cnt, 7);
      check_eq("t4_err_cnt", err_cnt, 0);

      // start while busy is ignored.
      start_run(10, 1'b0);
      repeat (3) tick(1'b1);
      start = 1'b1;
      tick(1'b1);
      start = 1'b0;
      run_to_done(1'b0);
      check_eq("t5_ignore_start_done_at", done_at, 14);

      // Reset mid-RUN after a counted failure.
      fault_n = 4;
      start_run(10, 1'b0);
      repeat (7) tick(1'b1);
      check_eq("t5_pre_err_cnt", err_cnt, 1);
      check_eq("t5_pre_busy", busy, 1);
      reset = 1'b1;
      tick(1'b1);
      reset = 1'b0;
      check_eq("t5_busy", busy, 0);
      check_eq("t5_done", done, 0);
      check_eq("t5_sub_ce", sub_ce, 0);
      check_eq("t5_err_cnt", err_cnt, 0);
      check_eq("t5_mismatch", mismatch, 0);

      // Zero-length run.
      fault_n = -1;
      start_run(0, 1'b0);
      run_to_done(1'b0);
      check_eq("t6_done_at", done_at, 4);
      check_eq("t6_sub_ce_cnt", sub_ce_cnt, 2);
      check_eq("t6_err_cnt", err_cnt, 0);
      check_eq("t6_mismatch", mismatch, 0);

      // CNT_W=4 instance: every compare fails, counter reaches all-ones.
      start4 = 1'b1;
      @(posedge clk);
      #1;
      start4 = 1'b0;
      n4 = 0;
      while (!done4 && n4 < 100) begin
         @(posedge clk);
         #1;
         n4++;
      end
      check_eq("sat_done_at", n4, 19);
      check_eq("sat_err_cnt", err_cnt4, 15);
      check_eq("sat_first_idx", first4, 0);
      check_eq("sat_mismatch", mismatch4, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
